// File: rtl/cdb_arbiter_if.sv
// Result-source and CDB broadcast bundle for cdb_arbiter.
// The master side is the execution units and the CDB consumers; the slave side is the arbiter.
interface cdb_arbiter_if #(
  parameter int SOURCES = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
);
  logic [SOURCES-1:0]             src_valid;
  logic [SOURCES-1:0]             src_ready;
  logic [SOURCES-1:0][TAG_W-1:0]  src_tag;
  logic [SOURCES-1:0][DATA_W-1:0] src_data;
  logic [1:0]                     cdb_valid;
  logic [1:0][TAG_W-1:0]          cdb_tag;
  logic [1:0][DATA_W-1:0]         cdb_data;

  modport master (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data
  );

  modport slave (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Two-lane CDB arbiter: one holding register per execution unit, round-robin pick of up
// to two held results per cycle, broadcast from registers.
module cdb_src_hold #(
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              acc_i,
  input  logic              gnt_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              held_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o
);
  logic              held_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_q;

  // A new accept wins over the grant so a source can stream one result per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_q <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (flush_i) begin
      held_q <= 1'b0;
    end else if (acc_i) begin
      held_q <= 1'b1;
      tag_q  <= tag_i;
      data_q <= data_i;
    end else if (gnt_i) begin
      held_q <= 1'b0;
    end
  end

  assign held_o = held_q;
  assign tag_o  = tag_q;
  assign data_o = data_q;
endmodule

module cdb_arbiter #(
  parameter int SOURCES = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);
  localparam int RR_W = $clog2(SOURCES);

  logic [SOURCES-1:0]             held, granted, accept;
  logic [SOURCES-1:0][TAG_W-1:0]  h_tag;
  logic [SOURCES-1:0][DATA_W-1:0] h_data;
  logic [RR_W-1:0]                rr_q, rr_d, g0, g1, last;
  logic                           g0_v, g1_v;
  logic [RR_W:0]                  sum;
  logic [1:0]                     cdb_valid_q;
  logic [1:0][TAG_W-1:0]          cdb_tag_q;
  logic [1:0][DATA_W-1:0]         cdb_data_q;

  for (genvar i = 0; i < SOURCES; i++) begin : g_src
    cdb_src_hold #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_hold (
      .clock  (clock),
      .reset  (reset),
      .flush_i(flush),
      .acc_i  (accept[i]),
      .gnt_i  (granted[i]),
      .tag_i  (bus.src_tag[i]),
      .data_i (bus.src_data[i]),
      .held_o (held[i]),
      .tag_o  (h_tag[i]),
      .data_o (h_data[i])
    );
  end

  // Walk the sources starting at rr; the first two held ones win lanes 0 and 1.
  always_comb begin
    g0   = '0;
    g1   = '0;
    g0_v = 1'b0;
    g1_v = 1'b0;
    sum  = '0;
    for (int k = 0; k < SOURCES; k++) begin
      sum = {1'b0, rr_q} + (RR_W+1)'(k);
      if (sum >= (RR_W+1)'(SOURCES)) sum = sum - (RR_W+1)'(SOURCES);
      if (held[sum[RR_W-1:0]]) begin
        if (!g0_v) begin
          g0   = sum[RR_W-1:0];
          g0_v = 1'b1;
        end else if (!g1_v) begin
          g1   = sum[RR_W-1:0];
          g1_v = 1'b1;
        end
      end
    end
  end

  always_comb begin
    granted = '0;
    for (int i = 0; i < SOURCES; i++)
      granted[i] = (g0_v && g0 == RR_W'(i)) || (g1_v && g1 == RR_W'(i));
  end

  always_comb begin
    last = g1_v ? g1 : g0;
    rr_d = rr_q;
    if (g0_v) rr_d = (last == RR_W'(SOURCES-1)) ? '0 : last + RR_W'(1);
  end

  assign bus.src_ready = {SOURCES{reset & ~flush}} & (~held | granted);
  assign accept        = bus.src_valid & bus.src_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q        <= '0;
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
    end else if (flush) begin
      rr_q        <= '0;
      cdb_valid_q <= '0;
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= {g1_v, g0_v};
      if (g0_v) begin
        cdb_tag_q[0]  <= h_tag[g0];
        cdb_data_q[0] <= h_data[g0];
      end
      if (g1_v) begin
        cdb_tag_q[1]  <= h_tag[g1];
        cdb_data_q[1] <= h_data[g1];
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized plus directed bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;
  localparam int S = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  cdb_arbiter_if #(.SOURCES(S), .TAG_W(6), .DATA_W(32)) bus ();

  cdb_arbiter #(.SOURCES(S), .TAG_W(6), .DATA_W(32)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // reference state
  bit          m_held [S];
  logic [5:0]  m_tag  [S];
  logic [31:0] m_data [S];
  int          m_rr;
  logic [1:0]  m_cv;
  logic [5:0]  m_ct   [2];
  logic [31:0] m_cd   [2];

  // stimulus values offered on the next step
  logic [5:0]  s_tag  [S];
  logic [31:0] s_data [S];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      m_held[i] = 1'b0;
      m_tag[i]  = '0;
      m_data[i] = '0;
    end
    m_rr = 0;
    m_cv = '0;
    for (int j = 0; j < 2; j++) begin
      m_ct[j] = '0;
      m_cd[j] = '0;
    end
  endtask

  // One clock: drive at negedge, check ready, then check the CDB just after the edge.
  task automatic step(input logic [S-1:0] v, input logic fl);
    int         gq[$];
    logic [S-1:0] gr, er;
    @(negedge clock);
    bus.src_valid = v;
    flush = fl;
    for (int i = 0; i < S; i++) begin
      bus.src_tag[i]  = s_tag[i];
      bus.src_data[i] = s_data[i];
    end
    gr = '0;
    for (int k = 0; k < S; k++) begin
      int idx;
      idx = (m_rr + k) % S;
      if (m_held[idx] && gq.size() < 2) begin
        gq.push_back(idx);
        gr[idx] = 1'b1;
      end
    end
    for (int i = 0; i < S; i++) er[i] = !fl && (!m_held[i] || gr[i]);
    #1 chk("src_ready", 64'(bus.src_ready), 64'(er));
    @(posedge clock);
    #1;
    if (fl) begin
      for (int i = 0; i < S; i++) m_held[i] = 1'b0;
      m_cv = '0;
      m_rr = 0;
    end else begin
      m_cv = '0;
      foreach (gq[j]) begin
        m_cv[j]      = 1'b1;
        m_ct[j]      = m_tag[gq[j]];
        m_cd[j]      = m_data[gq[j]];
        m_held[gq[j]] = 1'b0;
      end
      if (gq.size() > 0) m_rr = (gq[gq.size()-1] + 1) % S;
      for (int i = 0; i < S; i++)
        if (v[i] && er[i]) begin
          m_held[i] = 1'b1;
          m_tag[i]  = s_tag[i];
          m_data[i] = s_data[i];
        end
    end
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_cv));
    chk("cdb_tag", 64'(bus.cdb_tag), 64'({m_ct[1], m_ct[0]}));
    chk("cdb_data", 64'(bus.cdb_data), {m_cd[1], m_cd[0]});
  endtask

  initial begin
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.src_data  = '0;
    for (int i = 0; i < S; i++) begin
      s_tag[i]  = 6'(i + 1);
      s_data[i] = 32'h1000 + 32'(i);
    end
    model_reset();
    #1;
    chk("rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_ready", 64'(bus.src_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 chk("rel_ready", 64'(bus.src_ready), 64'hF);

    // reset in the middle of a burst
    step(4'b0111, 1'b0);
    step(4'b0000, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.cdb_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.src_ready), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    #1 chk("mid_rel_ready", 64'(bus.src_ready), 64'hF);

    // all four at once from rr=0: lanes {1,2} then {3,4}
    for (int i = 0; i < S; i++) s_tag[i] = 6'(i + 1);
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);
    chk("all_pair0", 64'(bus.cdb_tag), 64'({6'd2, 6'd1}));
    step(4'b0000, 1'b0);
    chk("all_pair1", 64'(bus.cdb_tag), 64'({6'd4, 6'd3}));
    step(4'b0000, 1'b0);

    // single result on lane 0, valid for one cycle
    s_tag[2]  = 6'd5;
    s_data[2] = 32'hDEADBEEF;
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    chk("single_valid", 64'(bus.cdb_valid), 64'b01);
    chk("single_tag", 64'(bus.cdb_tag[0]), 64'd5);
    chk("single_data", 64'(bus.cdb_data[0]), 64'hDEADBEEF);
    step(4'b0000, 1'b0);
    chk("single_gone", 64'(bus.cdb_valid), 64'd0);

    // wrap: rr=3 with sources 0 and 3 held
    s_tag[0] = 6'd30;
    s_tag[3] = 6'd33;
    step(4'b0100, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b0000, 1'b0);
    chk("wrap_tag", 64'(bus.cdb_tag), 64'({6'd30, 6'd33}));

    // streaming on source 1
    for (int k = 0; k < 6; k++) begin
      s_tag[1]  = 6'(10 + k);
      s_data[1] = 32'hA000 + 32'(k);
      step(4'b0010, 1'b0);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    // flush with sources 0 and 2 held
    step(4'b0101, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    chk("flush_none", 64'(bus.cdb_valid), 64'd0);

    // random traffic with occasional flush
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < S; i++) begin
        s_tag[i]  = 6'($urandom);
        s_data[i] = $urandom;
      end
      step(4'($urandom), ($urandom_range(0, 19) == 0));
    end
    step(4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
